// File: rtl/fighter_pkg.sv
// Shared action codes, FSM encoding and position helpers for the fighter datapath.
// Positions are one-hot with bit NUM_POS-1 as the leftmost arena cell.
package fighter_pkg;

    localparam logic [2:0] ACT_KICK   = 3'b000;
    localparam logic [2:0] ACT_PUNCH  = 3'b001;
    localparam logic [2:0] ACT_AWAIT  = 3'b010;
    localparam logic [2:0] ACT_JUMP   = 3'b011;
    localparam logic [2:0] ACT_LEFT1  = 3'b100;
    localparam logic [2:0] ACT_LEFT2  = 3'b101;
    localparam logic [2:0] ACT_RIGHT1 = 3'b110;
    localparam logic [2:0] ACT_RIGHT2 = 3'b111;

    // Upper bound on arena width handled by the index helpers.
    localparam int MAX_POS = 32;

    typedef enum logic [1:0] {
        ST_ALIVE = 2'd0,
        ST_STUN  = 2'd1,
        ST_KO    = 2'd2
    } state_t;

    function automatic int oh2idx(input logic [MAX_POS-1:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_POS; i++) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

    function automatic logic [MAX_POS-1:0] idx2oh(input int idx);
        logic [MAX_POS-1:0] v;
        for (int i = 0; i < MAX_POS; i++) begin
            v[i] = (i == idx);
        end
        return v;
    endfunction

    // Number of empty cells strictly between two occupied cells.
    function automatic int gap(input int a, input int b);
        if (a > b) return a - b - 1;
        else if (b > a) return b - a - 1;
        else return 0;
    endfunction

endpackage

// File: rtl/fighter_heal_ctr.sv
// Counts consecutive undamaged await steps; tc flags the step that reaches HEAL_WAIT.
// Single-cycle update, no backpressure; clear wins over inc, and the counter wraps to 0 on tc.
module fighter_heal_ctr #(
    parameter int HEAL_WAIT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clear,
    output logic tc
);

    localparam int CW = $clog2(HEAL_WAIT + 1);

    logic [CW-1:0] cnt;

    assign tc = inc && !clear && (cnt == CW'(HEAL_WAIT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || tc) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/fighter_player.sv
// Per-player combat engine: one step per actionEnable, results visible 1 cycle later; isGameOver/KO stall.
// Optional stun state after a hit is built when FIGHTER_STUN_EN is defined.
module fighter_player
    import fighter_pkg::*;
#(
    parameter int NUM_POS     = 3,
    parameter int SIDE        = 0,
    parameter int MAX_HEALTH  = 3,
    parameter int HEALTH_W    = 2,
    parameter int HEAL_WAIT   = 2,
    parameter int KICK_DMG    = 1,
    parameter int PUNCH_DMG   = 2,
    parameter int KICK_REACH  = 1,
    parameter int PUNCH_REACH = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                actionEnable,
    input  logic                isGameOver,
    input  logic [2:0]          action,
    input  logic [2:0]          opp_action,
    input  logic [NUM_POS-1:0]  opp_pos,
    output logic [NUM_POS-1:0]  pos,
    output logic [HEALTH_W-1:0] health,
    output logic                ko,
    output logic                hit,
    output logic                heal
);

    localparam logic [NUM_POS-1:0] HOME_OH  = (SIDE == 0) ? (NUM_POS'(1) << (NUM_POS - 1)) : NUM_POS'(1);
    localparam int                 OPP_HOME = (SIDE == 0) ? 0 : NUM_POS - 1;

    state_t              state_q, state_d;
    logic [NUM_POS-1:0]  pos_q, pos_d;
    logic [HEALTH_W-1:0] health_q, health_d;
    logic                hit_q, heal_q;
    logic                hit_d, heal_d;
    logic                step, stun_now;
    logic [2:0]          eff_act;
    logic                clash;
    int                  own_i, opp_i, mv_i, kb_i, nsteps, dir, g, dmg, h_int;
    logic                cnt_inc, cnt_clear, heal_tc;

`ifdef FIGHTER_STUN_EN
    assign stun_now = (state_q == ST_STUN);
`else
    assign stun_now = 1'b0;
`endif

    assign step = actionEnable && !isGameOver && (state_q != ST_KO);

    // Movement, gap and incoming damage, all against the opponent's current cell.
    always_comb begin
        own_i   = oh2idx(MAX_POS'(pos_q));
        opp_i   = $onehot(opp_pos) ? oh2idx(MAX_POS'(opp_pos)) : OPP_HOME;
        eff_act = stun_now ? ACT_AWAIT : action;
        nsteps  = 0;
        dir     = 0;
        case (eff_act)
            ACT_LEFT1:  begin nsteps = 1; dir = 1;  end
            ACT_LEFT2:  begin nsteps = 2; dir = 1;  end
            ACT_RIGHT1: begin nsteps = 1; dir = -1; end
            ACT_RIGHT2: begin nsteps = 2; dir = -1; end
            default:    begin nsteps = 0; dir = 0;  end
        endcase

        mv_i = own_i;
        for (int k = 0; k < 2; k++) begin
            if (k < nsteps && (mv_i + dir) >= 0 && (mv_i + dir) < NUM_POS && (mv_i + dir) != opp_i)
                mv_i = mv_i + dir;
        end

        g     = gap(mv_i, opp_i);
        clash = (eff_act == ACT_KICK) && (opp_action == ACT_KICK) && (g <= KICK_REACH);

        dmg = 0;
        if (!clash) begin
            if (opp_action == ACT_KICK && g <= KICK_REACH && eff_act != ACT_JUMP)
                dmg = KICK_DMG;
            else if (opp_action == ACT_PUNCH && g <= PUNCH_REACH)
                dmg = PUNCH_DMG;
        end

        // Clash knocks us one cell away from the opponent, edge permitting.
        kb_i = (opp_i < own_i) ? own_i + 1 : own_i - 1;
        if (clash)
            mv_i = (kb_i >= 0 && kb_i < NUM_POS) ? kb_i : own_i;

        pos_d = NUM_POS'(idx2oh(mv_i));
        hit_d = (dmg > 0);
    end

    assign cnt_inc   = step && (eff_act == ACT_AWAIT) && !hit_d && !stun_now;
    assign cnt_clear = step && !cnt_inc;

    fighter_heal_ctr #(
        .HEAL_WAIT (HEAL_WAIT)
    ) u_heal_ctr (
        .clk   (clk),
        .reset (reset),
        .inc   (cnt_inc),
        .clear (cnt_clear),
        .tc    (heal_tc)
    );

    always_comb begin
        h_int    = int'(health_q);
        health_d = health_q;
        heal_d   = 1'b0;
        if (hit_d) begin
            health_d = (h_int > dmg) ? HEALTH_W'(h_int - dmg) : '0;
        end else if (heal_tc && h_int < MAX_HEALTH) begin
            health_d = HEALTH_W'(h_int + 1);
            heal_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q    <= HOME_OH;
            health_q <= HEALTH_W'(MAX_HEALTH);
            hit_q    <= 1'b0;
            heal_q   <= 1'b0;
        end else begin
            hit_q  <= 1'b0;
            heal_q <= 1'b0;
            if (step) begin
                pos_q    <= pos_d;
                health_q <= health_d;
                hit_q    <= hit_d;
                heal_q   <= heal_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_ALIVE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (step) begin
            if (health_d == '0)
                state_d = ST_KO;
`ifdef FIGHTER_STUN_EN
            else if (hit_d && !stun_now)
                state_d = ST_STUN;
`endif
            else
                state_d = ST_ALIVE;
        end
    end

    always_comb begin
        ko = (state_q == ST_KO);
    end

    assign pos    = pos_q;
    assign health = health_q;
    assign hit    = hit_q;
    assign heal   = heal_q;

endmodule

// File: tb/tb_fighter_player.sv
// Directed self-checking bench: default SIDE0 arena plus a 5-cell instance for dash clamping.
module tb_fighter_player;

    localparam logic [2:0] K = 3'b000, P = 3'b001, AW = 3'b010, J = 3'b011;
    localparam logic [2:0] L1 = 3'b100, L2 = 3'b101, R1 = 3'b110, R2 = 3'b111;

    logic       clk, reset, ae, go;
    logic [2:0] act, oact, opos;
    logic [2:0] pos;
    logic [1:0] health;
    logic       ko, hit, heal;

    logic       ae5, go5;
    logic [2:0] act5, oact5;
    logic [4:0] opos5, pos5;
    logic [1:0] health5;
    logic       ko5, hit5, heal5;

    int checks = 0;
    int errors = 0;

    fighter_player dut (
        .clk(clk), .reset(reset), .actionEnable(ae), .isGameOver(go),
        .action(act), .opp_action(oact), .opp_pos(opos),
        .pos(pos), .health(health), .ko(ko), .hit(hit), .heal(heal)
    );

    fighter_player #(.NUM_POS(5)) dut5 (
        .clk(clk), .reset(reset), .actionEnable(ae5), .isGameOver(go5),
        .action(act5), .opp_action(oact5), .opp_pos(opos5),
        .pos(pos5), .health(health5), .ko(ko5), .hit(hit5), .heal(heal5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; ae = 1'b0; ae5 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic do_step(input logic [2:0] a, input logic [2:0] oa, input logic [2:0] op);
        @(negedge clk);
        act = a; oact = oa; opos = op; ae = 1'b1;
        @(negedge clk);
        ae = 1'b0;
    endtask

    task automatic do_step5(input logic [2:0] a, input logic [2:0] oa, input logic [4:0] op);
        @(negedge clk);
        act5 = a; oact5 = oa; opos5 = op; ae5 = 1'b1;
        @(negedge clk);
        ae5 = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pos !== 3'b100) begin errors++; $display("FAIL reset_pos: got %b want 100", pos); end
        checks++; if (health !== 2'd3) begin errors++; $display("FAIL reset_health: got %0d want 3", health); end
        checks++; if ({ko, hit, heal} !== 3'b000) begin errors++; $display("FAIL reset_flags: ko/hit/heal got %b want 000", {ko, hit, heal}); end
        checks++; if (pos5 !== 5'b10000) begin errors++; $display("FAIL reset_pos5: got %b want 10000", pos5); end
    endtask

    task automatic test_move();
        do_reset();
        do_step(R1, AW, 3'b001);
        checks++; if (pos !== 3'b010) begin errors++; $display("FAIL move_r1: got %b want 010", pos); end
        do_step(R1, AW, 3'b001);
        checks++; if (pos !== 3'b010 || hit !== 1'b0) begin errors++; $display("FAIL move_blocked: pos %b hit %b want 010 0", pos, hit); end
        do_step(L2, AW, 3'b001);
        checks++; if (pos !== 3'b100) begin errors++; $display("FAIL move_l2_edge: got %b want 100", pos); end
        go = 1'b1;
        do_step(R1, K, 3'b001);
        go = 1'b0;
        checks++; if (pos !== 3'b100 || health !== 2'd3) begin errors++; $display("FAIL game_over_hold: pos %b health %0d want 100 3", pos, health); end
    endtask

    task automatic test_dash();
        do_reset();
        do_step5(R2, AW, 5'b00001);
        checks++; if (pos5 !== 5'b00100) begin errors++; $display("FAIL dash_r2: got %b want 00100", pos5); end
        do_step5(R2, AW, 5'b00001);
        checks++; if (pos5 !== 5'b00010) begin errors++; $display("FAIL dash_clamp: got %b want 00010", pos5); end
    endtask

    task automatic test_bad_opp();
        do_reset();
        do_step(R2, AW, 3'b000);
        checks++; if (pos !== 3'b010) begin errors++; $display("FAIL bad_opp_zero: got %b want 010", pos); end
        do_reset();
        do_step(R2, AW, 3'b011);
        checks++; if (pos !== 3'b010) begin errors++; $display("FAIL bad_opp_multi: got %b want 010", pos); end
    endtask

    task automatic test_damage();
        do_reset();
        do_step(R1, AW, 3'b001);
        do_step(AW, K, 3'b001);
        checks++; if (health !== 2'd2 || hit !== 1'b1) begin errors++; $display("FAIL kick_lands: health %0d hit %b want 2 1", health, hit); end
        @(negedge clk);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL hit_pulse: got %b want 0", hit); end
        do_reset();
        do_step(R1, AW, 3'b001);
        do_step(J, K, 3'b001);
        checks++; if (health !== 2'd3 || hit !== 1'b0) begin errors++; $display("FAIL jump_dodge: health %0d hit %b want 3 0", health, hit); end
        do_step(J, P, 3'b001);
        checks++; if (health !== 2'd1 || hit !== 1'b1) begin errors++; $display("FAIL punch_vs_jump: health %0d hit %b want 1 1", health, hit); end
        do_reset();
        do_step(AW, K, 3'b001);
        checks++; if (health !== 2'd2) begin errors++; $display("FAIL kick_reach1: health %0d want 2", health); end
        do_step(J, AW, 3'b001);
        do_step(AW, P, 3'b001);
        checks++; if (health !== 2'd2 || hit !== 1'b0) begin errors++; $display("FAIL punch_out_of_reach: health %0d hit %b want 2 0", health, hit); end
    endtask

    task automatic test_clash();
        do_reset();
        do_step(R1, AW, 3'b001);
        do_step(K, K, 3'b001);
        checks++; if (pos !== 3'b100 || health !== 2'd3 || hit !== 1'b0) begin errors++; $display("FAIL clash: pos %b health %0d hit %b want 100 3 0", pos, health, hit); end
    endtask

    task automatic test_ko();
        do_reset();
        do_step(R1, AW, 3'b001);
        do_step(AW, K, 3'b001);
        do_step(AW, K, 3'b001);
        checks++; if (health !== 2'd1) begin errors++; $display("FAIL ko_pre: health %0d want 1", health); end
        do_step(AW, P, 3'b001);
        checks++; if (health !== 2'd0 || ko !== 1'b1 || hit !== 1'b1) begin errors++; $display("FAIL ko_enter: health %0d ko %b hit %b want 0 1 1", health, ko, hit); end
        do_step(L1, K, 3'b001);
        checks++; if (pos !== 3'b010 || health !== 2'd0 || hit !== 1'b0 || ko !== 1'b1) begin errors++; $display("FAIL ko_hold: pos %b health %0d hit %b ko %b", pos, health, hit, ko); end
        do_reset();
        checks++; if (pos !== 3'b100 || health !== 2'd3 || ko !== 1'b0) begin errors++; $display("FAIL ko_reset: pos %b health %0d ko %b want 100 3 0", pos, health, ko); end
    endtask

    task automatic test_heal();
        do_reset();
        do_step(R1, AW, 3'b001);
        do_step(AW, K, 3'b001);
        do_step(J, AW, 3'b001);
        do_step(AW, AW, 3'b001);
        checks++; if (health !== 2'd2 || heal !== 1'b0) begin errors++; $display("FAIL heal_first: health %0d heal %b want 2 0", health, heal); end
        do_step(AW, AW, 3'b001);
        checks++; if (health !== 2'd3 || heal !== 1'b1) begin errors++; $display("FAIL heal_second: health %0d heal %b want 3 1", health, heal); end
        do_step(AW, K, 3'b001);
        do_step(J, AW, 3'b001);
        do_step(AW, AW, 3'b001);
        do_step(P, AW, 3'b001);
        do_step(AW, AW, 3'b001);
        checks++; if (health !== 2'd2 || heal !== 1'b0) begin errors++; $display("FAIL heal_interrupted: health %0d heal %b want 2 0", health, heal); end
        do_step(AW, AW, 3'b001);
        checks++; if (health !== 2'd3 || heal !== 1'b1) begin errors++; $display("FAIL heal_resume: health %0d heal %b want 3 1", health, heal); end
        do_step(AW, AW, 3'b001);
        do_step(AW, AW, 3'b001);
        checks++; if (health !== 2'd3 || heal !== 1'b0) begin errors++; $display("FAIL heal_at_max: health %0d heal %b want 3 0", health, heal); end
    endtask

    task automatic test_stun();
        do_reset();
        do_step(R1, AW, 3'b001);
        do_step(AW, K, 3'b001);
        do_step(L1, AW, 3'b001);
`ifdef FIGHTER_STUN_EN
        checks++; if (pos !== 3'b010) begin errors++; $display("FAIL stun_ignores_move: got %b want 010", pos); end
        do_step(L1, AW, 3'b001);
        checks++; if (pos !== 3'b100) begin errors++; $display("FAIL stun_release: got %b want 100", pos); end
`else
        checks++; if (pos !== 3'b100) begin errors++; $display("FAIL move_after_hit: got %b want 100", pos); end
`endif
    endtask

    initial begin
        reset = 1'b0; ae = 1'b0; go = 1'b0; act = AW; oact = AW; opos = 3'b001;
        ae5 = 1'b0; go5 = 1'b0; act5 = AW; oact5 = AW; opos5 = 5'b00001;
        test_reset();
        test_move();
        test_dash();
        test_bad_opp();
        test_damage();
        test_clash();
        test_ko();
        test_heal();
        test_stun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
